mult_div_seq: RTL

//  Iterative multiply/divide sequencer owning the HI/LO pair for MULT/MULTU/DIV/DIVU/MTHI/MTLO.

---
 rtl/mult_div_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mult_div_seq.sv
// mult_div_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO (radix-2 shift-add / restoring)
// Optional MD_EARLY_TERM_EN: multiplies stop after msb_index(|y|)+1 iterations.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] md_op_x,
  input  logic [WIDTH-1:0] md_op_y,
  input  logic             md_abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] md_wr_data,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt, mul_last;
  logic [2*WIDTH-1:0] acc, prod, mul_next, div_next, res;
  logic [WIDTH-1:0] mx, my, ax, ay, div_diff;
  logic [WIDTH:0] mul_sum;
  logic sx, sy, is_div, dz, x_neg, y_neg, div_ge;
`ifdef MD_EARLY_TERM_EN
  logic [CW-1:0] sh;
  function automatic logic [CW-1:0] msb_idx(input logic [WIDTH-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) msb_idx = CW'(i);
  endfunction
  assign mul_last = msb_idx(ay);
  // a shortened run leaves the product high in acc; realign by the skipped count
  assign prod = acc >> sh;
`else
  assign mul_last = CW'(WIDTH - 1);
  assign prod = acc;
`endif
  assign md_busy = state != S_IDLE;
  always_comb begin
    x_neg = ~md_op[0] & md_op_x[WIDTH-1];
    y_neg = ~md_op[0] & md_op_y[WIDTH-1];
    ax = x_neg ? -md_op_x : md_op_x;
    ay = y_neg ? -md_op_y : md_op_y;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, mx} & {(WIDTH+1){acc[0]}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    // acc = {remainder, quotient}; shifted remainder is acc[2W-1:W-1]
    div_ge = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, my};
    div_diff = acc[2*WIDTH-2:WIDTH-1] - my;
    div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    res = dz ? acc
        : is_div ? {sx ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
                    (sx ^ sy) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]}
        : (sx ^ sy) ? -prod : prod;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      hi <= '0;
      lo <= '0;
      md_done <= 1'b0;
      md_div_zero <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mx <= '0;
      my <= '0;
      sx <= 1'b0;
      sy <= 1'b0;
      is_div <= 1'b0;
      dz <= 1'b0;
`ifdef MD_EARLY_TERM_EN
      sh <= '0;
`endif
    end else begin
      md_done <= 1'b0;
      md_div_zero <= 1'b0;
      if (md_abort && state != S_IDLE) state <= S_IDLE;
      else case (state)
        S_IDLE: begin
          if (hi_we) hi <= md_wr_data;
          if (lo_we) lo <= md_wr_data;
          if (md_start && !md_abort) begin
            is_div <= md_op[1];
            sx <= x_neg;
            sy <= y_neg;
            mx <= ax;
            my <= ay;
            dz <= md_op[1] && md_op_y == '0;
            if (md_op[1] && md_op_y == '0) begin
              acc <= {md_op_x, {WIDTH{1'b1}}};
              state <= S_FIX;
            end else if (md_op[1]) begin
              acc <= {{WIDTH{1'b0}}, ax};
              cnt <= CW'(WIDTH - 1);
              state <= S_DIV;
            end else begin
              acc <= {{WIDTH{1'b0}}, ay};
              cnt <= mul_last;
              state <= S_MUL;
`ifdef MD_EARLY_TERM_EN
              sh <= CW'(WIDTH - 1) - mul_last;
`endif
            end
          end
        end
        S_MUL, S_DIV: begin
          acc <= state == S_MUL ? mul_next : div_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= S_FIX;
        end
        default: begin
          hi <= res[2*WIDTH-1:WIDTH];
          lo <= res[WIDTH-1:0];
          md_done <= 1'b1;
          md_div_zero <= dz;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
